// File: rtl/hello_hw_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port program/data RAM.
// Out-of-range accesses are absorbed here and never reach the RAM.
module hello_hw_ram_arbiter #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BE_W      = 4,
    parameter int unsigned MEM_WORDS = 10240,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              freeze,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    output logic              ram_clken,
    input  logic [DATA_W-1:0] ram_readdata,

    output logic [CNT_W-1:0]  contention_count,
    output logic              oob_access
);

    logic              m0_req, m1_req;
    logic              gnt0, gnt1, gnt_any;
    logic [ADDR_W-1:0] g_addr;
    logic [BE_W-1:0]   g_be;
    logic [DATA_W-1:0] g_wdata;
    logic              g_wr, g_rd, in_range;

    logic              last_grant_q, last_grant_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_own_q, rd_own_d;
    logic              rd_oob_q, rd_oob_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              oob_q, oob_d;

    // Grant decision; last_grant_q holds the index of the most recent winner.
    always_comb begin
        m0_req = m0_read | m0_write;
        m1_req = m1_read | m1_write;
        gnt0   = 1'b0;
        gnt1   = 1'b0;
        if (!reset && !freeze) begin
            if (m0_req && m1_req) begin
                gnt0 = last_grant_q;
                gnt1 = ~last_grant_q;
            end else begin
                gnt0 = m0_req;
                gnt1 = m1_req;
            end
        end
        gnt_any = gnt0 | gnt1;
    end

    always_comb begin
        g_addr  = gnt1 ? m1_address    : m0_address;
        g_be    = gnt1 ? m1_byteenable : m0_byteenable;
        g_wdata = gnt1 ? m1_writedata  : m0_writedata;
        // Write wins when a master raises read and write together.
        g_wr     = gnt_any & (gnt1 ? m1_write : m0_write);
        g_rd     = gnt_any & ~g_wr;
        in_range = 32'(g_addr) < MEM_WORDS;
    end

    always_comb begin
        m0_waitrequest = ~gnt0;
        m1_waitrequest = ~gnt1;
        ram_address    = gnt_any ? g_addr  : '0;
        ram_byteenable = gnt_any ? g_be    : '0;
        ram_writedata  = gnt_any ? g_wdata : '0;
        ram_chipselect = gnt_any & in_range;
        ram_write      = g_wr & in_range;
        ram_clken      = 1'b1;
    end

    always_comb begin
        last_grant_d = gnt_any ? gnt1 : last_grant_q;
        rd_vld_d     = g_rd;
        rd_own_d     = gnt1;
        rd_oob_d     = ~in_range;
        cnt_d        = cnt_q;
        if (m0_req && m1_req && !freeze && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        oob_d = oob_q | (gnt_any & ~in_range);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_vld_q     <= 1'b0;
            rd_own_q     <= 1'b0;
            rd_oob_q     <= 1'b0;
            cnt_q        <= '0;
            oob_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_vld_q     <= rd_vld_d;
            rd_own_q     <= rd_own_d;
            rd_oob_q     <= rd_oob_d;
            cnt_q        <= cnt_d;
            oob_q        <= oob_d;
        end
    end

    always_comb begin
        m0_readdatavalid = rd_vld_q & ~rd_own_q;
        m1_readdatavalid = rd_vld_q & rd_own_q;
        m0_readdata      = (m0_readdatavalid && !rd_oob_q) ? ram_readdata : '0;
        m1_readdata      = (m1_readdatavalid && !rd_oob_q) ? ram_readdata : '0;
        contention_count = cnt_q;
        oob_access       = oob_q;
    end

endmodule

// File: tb/tb_hello_hw_ram_arbiter.sv
// Bench for hello_hw_ram_arbiter: behavioural RAM, reference model feeding
// per-master expected-read queues, and a monitor that drains them.
module tb_hello_hw_ram_arbiter;

    localparam int MW = 10240;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        freeze = 1'b0;
    logic [13:0] m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata = '0;
    logic [15:0] contention_count;
    logic        oob_access;

    // Second instance with a 4-bit counter, only its counter is checked.
    logic        s_w0, s_w1, s_v0, s_v1, s_cs, s_we, s_ce, s_oob;
    logic [31:0] s_rd0, s_rd1, s_wd;
    logic [13:0] s_a;
    logic [3:0]  s_be;
    logic [3:0]  s_cnt;

    always #5 clk = ~clk;

    hello_hw_ram_arbiter u_dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_chipselect(ram_chipselect), .ram_write(ram_write),
        .ram_writedata(ram_writedata), .ram_clken(ram_clken), .ram_readdata(ram_readdata),
        .contention_count(contention_count), .oob_access(oob_access)
    );

    hello_hw_ram_arbiter #(.CNT_W(4)) u_sat (
        .clk(clk), .reset(reset), .freeze(freeze),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(s_w0),
        .m0_readdata(s_rd0), .m0_readdatavalid(s_v0),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(s_w1),
        .m1_readdata(s_rd1), .m1_readdatavalid(s_v1),
        .ram_address(s_a), .ram_byteenable(s_be), .ram_chipselect(s_cs), .ram_write(s_we),
        .ram_writedata(s_wd), .ram_clken(s_ce), .ram_readdata(ram_readdata),
        .contention_count(s_cnt), .oob_access(s_oob)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [31:0] ram_mem [0:16383];
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] = ram_writedata[8*b +: 8];
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:16383];
    int          last_ref = 1;
    int          cnt_ref = 0;
    int          cnt4_ref = 0;
    bit          oob_ref = 1'b0;
    int          g_now = -1;
    typedef struct { logic [31:0] data; int due; } exp_t;
    exp_t        q0[$];
    exp_t        q1[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] last_rd0 = '0, last_rd1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic mon(input int m, input logic v, input logic [31:0] d);
        exp_t e;
        int   n;
        n = (m == 0) ? q0.size() : q1.size();
        if (n > 0) begin
            if (m == 0) e = q0[0]; else e = q1[0];
        end
        if (n > 0 && e.due <= cyc) begin
            if (m == 0) e = q0.pop_front(); else e = q1.pop_front();
            chk($sformatf("m%0d_readdatavalid", m), 64'(v), 64'(1));
            chk($sformatf("m%0d_readdata", m), 64'(d), 64'(e.data));
            if (m == 0) last_rd0 = d; else last_rd1 = d;
        end else begin
            chk($sformatf("m%0d_unexpected_valid", m), 64'(v), 64'(0));
            chk($sformatf("m%0d_idle_readdata", m), 64'(d), 64'(0));
        end
    endtask

    // Monitor: reset discards anything in flight.
    always @(negedge clk) begin
        if (reset) begin
            q0.delete();
            q1.delete();
        end else begin
            mon(0, m0_readdatavalid, m0_readdata);
            mon(1, m1_readdatavalid, m1_readdata);
        end
    end

    // One cycle: check against the model at the negedge, advance the model, return at posedge+1.
    task automatic step();
        int          g;
        logic        r0, r1, wr, rd, inr;
        logic [13:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [51:0] eb;
        exp_t        e;
        @(negedge clk);
        if (reset) begin
            last_ref = 1; cnt_ref = 0; cnt4_ref = 0; oob_ref = 1'b0;
        end
        chk("contention_count", 64'(contention_count), 64'(cnt_ref));
        chk("contention_count_w4", 64'(s_cnt), 64'(cnt4_ref));
        chk("oob_access", 64'(oob_access), 64'(oob_ref));
        chk("ram_clken", 64'(ram_clken), 64'(1));
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        g = -1;
        if (!reset && !freeze) begin
            if (r0 && r1) g = (last_ref == 0) ? 1 : 0;
            else if (r0) g = 0;
            else if (r1) g = 1;
        end
        chk("m0_waitrequest", 64'(m0_waitrequest), 64'(g != 0));
        chk("m1_waitrequest", 64'(m1_waitrequest), 64'(g != 1));
        eb = '0;
        if (g >= 0) begin
            a  = (g == 1) ? m1_address : m0_address;
            be = (g == 1) ? m1_byteenable : m0_byteenable;
            wd = (g == 1) ? m1_writedata : m0_writedata;
            wr = (g == 1) ? m1_write : m0_write;
            rd = !wr;
            inr = int'(a) < MW;
            eb = {inr, wr & inr, a, be, wd};
            last_ref = g;
            if (!inr) oob_ref = 1'b1;
            if (wr && inr) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            end else if (rd) begin
                e.data = inr ? ref_mem[a] : 32'h0;
                e.due  = cyc + 1;
                if (g == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
        chk("ram_bus", 64'({ram_chipselect, ram_write, ram_address, ram_byteenable,
                            ram_writedata}), 64'(eb));
        if (!reset && !freeze && r0 && r1) begin
            if (cnt_ref < 65535) cnt_ref++;
            if (cnt4_ref < 15) cnt4_ref++;
        end
        g_now = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic rd, input logic wr, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        if (m == 0) begin
            m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
        end else begin
            m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
        end
    endtask

    task automatic rand_tx(input int m, output bit pend);
        int          k;
        logic [13:0] a;
        k = $urandom_range(0, 9);
        a = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(MW, 16383))
                                        : 14'($urandom_range(0, 31));
        if (k <= 2) set_m(m, 1'b0, 1'b0, '0, '0, '0);
        else set_m(m, k <= 6 || k == 9, k >= 7, a, 4'($urandom_range(1, 15)), $urandom);
        pend = (k > 2);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        bit p0, p1;
        for (int i = 0; i < 16384; i++) begin
            ram_mem[i] = 32'h5A00_0000 ^ (i * 32'h9E37);
            ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h9E37);
        end
        ram_mem[5]  = 32'h12345678; ref_mem[5]  = 32'h12345678;
        ram_mem[16] = 32'h11111111; ref_mem[16] = 32'h11111111;

        do_reset();
        // Single read after reset.
        set_m(0, 1'b1, 1'b0, 14'h0005, 4'hF, '0);
        step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("t1_readdata", 64'(last_rd0), 64'h12345678);

        // Continuous contention for 6 cycles.
        set_m(0, 1'b1, 1'b0, 14'h0001, 4'hF, '0);
        set_m(1, 1'b1, 1'b0, 14'h0002, 4'hF, '0);
        for (int i = 0; i < 6; i++) step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("t2_contention", 64'(contention_count), 64'd6);

        // Partial write then read-back.
        set_m(1, 1'b0, 1'b1, 14'h0010, 4'h3, 32'hAABBCCDD);
        step();
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        set_m(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0);
        step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("t3_merged", 64'(last_rd0), 64'h1111CCDD);

        // Out-of-range write and read.
        set_m(0, 1'b0, 1'b1, 14'h2800, 4'hF, 32'hDEADBEEF);
        step();
        set_m(0, 1'b1, 1'b0, 14'h2800, 4'hF, '0);
        step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        step();
        chk("t4_oob_read", 64'(last_rd0), 64'h0);
        chk("t4_oob_flag", 64'(oob_access), 64'h1);

        // Freeze after a granted read.
        set_m(0, 1'b1, 1'b0, 14'h0003, 4'hF, '0);
        step();
        set_m(0, 1'b1, 1'b0, 14'h0004, 4'hF, '0);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) step();
        freeze = 1'b0;
        step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        step();

        // Reset with a read in flight.
        set_m(0, 1'b1, 1'b0, 14'h0007, 4'hF, '0);
        step();
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        do_reset();
        step();
        set_m(0, 1'b1, 1'b0, 14'h0008, 4'hF, '0);
        set_m(1, 1'b1, 1'b0, 14'h0009, 4'hF, '0);
        #1;
        chk("t6_m0_first", 64'(m0_waitrequest), 64'h0);
        step();

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) step();
        chk("t7_saturated", 64'(s_cnt), 64'hF);

        // Randomized traffic with a mid-run reset.
        p0 = 1'b0; p1 = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!p0) rand_tx(0, p0);
            if (!p1) rand_tx(1, p1);
            freeze = ($urandom_range(0, 7) == 0);
            reset = (i == 200);
            step();
            if (g_now == 0) p0 = 1'b0;
            if (g_now == 1) p1 = 1'b0;
        end
        reset = 1'b0;
        freeze = 1'b0;
        set_m(0, 1'b0, 1'b0, '0, '0, '0);
        set_m(1, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 3; i++) step();
        chk("drained", 64'(q0.size() + q1.size()), 64'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hello_hw_ram_arbiter.md
Name: hello_hw_ram_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port 32-bit on-chip program/data RAM (10240 words, 14-bit word address, byte enables, 1-cycle read latency).
- Lets the CPU data master (m0) and a DMA/debug master (m1) share the one RAM port.
- Each master sees an Avalon-MM slave with waitrequest and readdatavalid.
- Out-of-range addresses never reach the RAM. A saturating counter records contention cycles.

Parameters:
- ADDR_W, 14, word address width
- DATA_W, 32, data width
- BE_W, 4, byte-enable width (DATA_W/8)
- MEM_WORDS, 10240, valid words; address >= MEM_WORDS is out of range
- CNT_W, 16, contention counter width

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- freeze  in  1  high = grant nothing new
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  BE_W  master 0 byte enables
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same seven ports as m0, for master 1
- ram_address  out  ADDR_W  to RAM
- ram_byteenable  out  BE_W  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_writedata  out  DATA_W  to RAM
- ram_clken  out  1  RAM clock enable, tied 1
- ram_readdata  in  DATA_W  RAM read data, valid 1 cycle after read address
- contention_count  out  CNT_W  saturating count of cycles with both masters requesting
- oob_access  out  1  sticky flag: an out-of-range access occurred

Behaviour:
- Request: mN_req = mN_read | mN_write. read & write together on the same master = write. readdata is not returned for it.
- Arbitration is combinational each cycle:
  - freeze=1: no grant.
  - Only one master requesting: that master is granted.
  - Both requesting: grant the master not in last_grant.
- Acceptance: a granted master has waitrequest=0 this cycle. The access is accepted on this clk edge. Every non-granted requester has waitrequest=1.
- Idle master waitrequest = 1. Both masters must hold their signals stable while stalled.
- last_grant register updates to the granted master on every grant. It holds when there is no grant.
- RAM drive, same cycle as grant:
  - ram_address, ram_byteenable and ram_writedata are muxed from the granted master.
  - ram_chipselect = grant & in-range.
  - ram_write = granted write & in-range.
  - With no grant, all RAM outputs are 0 except ram_clken.
- Read return pipeline, one stage registered on clk:
  - rd_vld <= granted read.
  - rd_own <= granted master index.
  - rd_oob <= address out of range.
  - The next cycle, mN_readdatavalid = rd_vld & (rd_own==N).
  - mN_readdata = rd_oob ? 0 : ram_readdata when valid; 0 otherwise.
- Read latency is exactly 1 cycle from acceptance. Back-to-back reads are allowed from either master, giving full throughput of 1 access/cycle.
- Out-of-range accesses:
  - A write is accepted and dropped.
  - A read is accepted and returns 0x00000000.
  - Both set oob_access, which is cleared only by reset.
- contention_count increments by 1 each cycle where m0_req & m1_req & ~freeze. It saturates at all-ones.
- freeze does not suppress a readdatavalid already in the pipeline.
- Reset (async, high):
  - last_grant=1, so m0 wins first contention.
  - rd_vld=0, rd_own=0, rd_oob=0.
  - contention_count=0, oob_access=0.
  - All readdatavalid=0 and readdata=0.
  - waitrequest=1 while reset is asserted.
  - An in-flight read is discarded: no readdatavalid after reset releases.
- Simultaneous write from one master and read from the other to the same address, granted on consecutive cycles: the read sees the RAM's read-during-write result. Order is purely the grant order.

Test Plan:
- Reset release, m0 reads address 0x0005 (RAM holds 0x12345678) -> m0_waitrequest=0 in cycle 0; m0_readdatavalid=1 with 0x12345678 in cycle 1; m1 signals idle.
- m0 and m1 both read continuously for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each master gets readdatavalid every other cycle; contention_count=6.
- m1 writes 0xAABBCCDD with byteenable 0x3 to 0x0010, then m0 reads 0x0010 (initial 0x11111111) -> m0 readdata 0x1111CCDD.
- m0 write to 0x2800 (10240) then read 0x2800 -> ram_chipselect stays 0; read returns 0 with readdatavalid; oob_access=1 until reset.
- freeze=1 while m0 requests for 3 cycles -> m0_waitrequest=1 all 3 cycles, no RAM chipselect; a read granted the cycle before freeze still returns readdatavalid.
- Assert reset the cycle after a read is granted -> no readdatavalid after release; contention_count=0; first contended cycle afterwards grants m0.
- Force contention_count to near saturation (CNT_W=4, 20 contended cycles) -> count holds at 0xF.
